// File: rtl/pc_stack_unit_pkg.sv
// pc_pkg: op codes and default sizes shared by the program-counter unit and its bench
package pc_pkg;
  typedef enum logic [2:0] {PC_INC, PC_SKIP, PC_GOTO, PC_CALL, PC_RET, PC_HOLD} pc_op_t;
  localparam int PC_W_DEF = 13;
  localparam int DEPTH_DEF = 8;
endpackage

// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if: decode-side request bundle and registered fetch-address/stack status
interface pc_stack_unit_if #(parameter int PC_W = pc_pkg::PC_W_DEF, parameter int DEPTH = pc_pkg::DEPTH_DEF);
  logic en;
  logic [2:0] op;
  logic [PC_W-1:0] target;
  logic clr_flags;
  logic [PC_W-1:0] counter;
  logic [$clog2(DEPTH):0] depth;
  logic stk_overflow;
  logic stk_underflow;
  modport master(output en, op, target, clr_flags, input counter, depth, stk_overflow, stk_underflow);
  modport slave(input en, op, target, clr_flags, output counter, depth, stk_overflow, stk_underflow);
endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// ret_stack: circular LIFO of return addresses; overflow overwrites the oldest, underflow pops anyway
module ret_stack #(parameter int PC_W = 13, parameter int DEPTH = 8) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [PC_W-1:0] wdata,
  output logic [PC_W-1:0] rdata,
  output logic [$clog2(DEPTH):0] depth,
  output logic overflow,
  output logic underflow
);
  localparam int SW = $clog2(DEPTH);
  logic [PC_W-1:0] r_mem [DEPTH];
  logic [SW-1:0] r_sp, w_top;
  logic [SW:0] r_depth;
  assign w_top = r_sp - SW'(1);
  assign rdata = r_mem[w_top];
  assign depth = r_depth;
  assign overflow = push && r_depth == (SW+1)'(DEPTH);
  assign underflow = pop && r_depth == '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
      r_depth <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      r_mem[r_sp] <= wdata;
      r_sp <= r_sp + SW'(1);
      r_depth <= overflow ? r_depth : r_depth + (SW+1)'(1);
    end else if (pop) begin
      r_sp <= w_top;
      r_depth <= underflow ? r_depth : r_depth - (SW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with increment/skip/goto/call/return and sticky stack flags
module pc_stack_unit import pc_pkg::*; #(
  parameter int PC_W = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input logic clk,
  input logic reset,
  pc_stack_unit_if.slave bus
);
  logic [PC_W-1:0] r_counter, w_next, w_rdata;
  logic [$clog2(DEPTH):0] w_depth;
  logic w_push, w_pop, w_ovf, w_unf, r_ovf, r_unf;
  assign w_push = bus.en && bus.op == PC_CALL;
  assign w_pop = bus.en && bus.op == PC_RET;
  ret_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(w_push), .pop(w_pop), .wdata(r_counter + PC_W'(1)),
    .rdata(w_rdata), .depth(w_depth), .overflow(w_ovf), .underflow(w_unf)
  );
  // codes 6 and 7 fall through to the increment arm
  always_comb begin
    w_next = !bus.en ? r_counter :
             bus.op == PC_SKIP ? r_counter + PC_W'(2) :
             (bus.op == PC_GOTO || bus.op == PC_CALL) ? bus.target :
             bus.op == PC_RET ? w_rdata :
             bus.op == PC_HOLD ? r_counter : r_counter + PC_W'(1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_counter <= RESET_VEC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_counter <= w_next;
      r_ovf <= w_ovf ? 1'b1 : bus.clr_flags ? 1'b0 : r_ovf;
      r_unf <= w_unf ? 1'b1 : bus.clr_flags ? 1'b0 : r_unf;
    end
  end
  assign bus.counter = r_counter;
  assign bus.depth = w_depth;
  assign bus.stk_overflow = r_ovf;
  assign bus.stk_underflow = r_unf;
endmodule
